// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter and fetch sequencer. It sits between the branch-target mux
//   and instruction memory. It holds the PC and requests each instruction over
//   a req/ack handshake. It then presents the instruction for one execute slot.
//   After that slot the PC advances by one, loads the jump target, or the
//   sequencer halts.
//
// Parameters
//   PC_W       width of pc, jump_target and imem_addr
//   IMEM_DEPTH number of valid instruction words (legal pc 0..IMEM_DEPTH-1)
//   START_PC   pc loaded on start
//   CNT_W      width of the saturating retired-instruction counter
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   start        in   begin execution at START_PC (honoured in IDLE/HALTED)
//   stall        in   hold the current execute slot
//   jump_en      in   take jump_target this execute slot
//   jump_target  in   jump destination
//   halt_req     in   current instruction is a halt
//   imem_ack     in   instruction memory accepts/returns the fetch
//   imem_req     out  fetch request
//   imem_addr    out  fetch address (always equal to pc)
//   instr_valid  out  execute slot active; control inputs sampled
//   pc           out  current program counter
//   done         out  high while halted
//   fault        out  high while halted because pc left the legal range
//   retire_cnt   out  instructions retired since the last start
module pc_sequencer #(
  parameter int unsigned PC_W       = 16,
  parameter int unsigned IMEM_DEPTH = 128,
  parameter int unsigned START_PC   = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             jump_en,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             halt_req,
  input  logic             imem_ack,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  pc,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t state;

  // The range checks use one extra bit. Without it, pc+1 or a wide target
  // could wrap and pass the check. Nothing is allowed to wrap back into range.
  localparam logic [PC_W:0]   DEPTH_EXT = (PC_W+1)'(IMEM_DEPTH);
  localparam logic [PC_W-1:0] START_VAL = PC_W'(START_PC);

  logic [PC_W:0]  pc_inc;
  logic           seq_ok;
  logic           jump_ok;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    pc_inc  = {1'b0, pc} + (PC_W+1)'(1);
    seq_ok  = (pc_inc < DEPTH_EXT);
    jump_ok = ({1'b0, jump_target} < DEPTH_EXT);
    cnt_inc = (retire_cnt == '1) ? retire_cnt : retire_cnt + CNT_W'(1);
  end

  assign imem_addr = pc;

  // The req, valid and done flags are registered with the state. This means
  // each flag always matches the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc         <= START_VAL;
            retire_cnt <= '0;
            fault      <= 1'b0;
            imem_req   <= 1'b1;
            state      <= S_FETCH;
          end
        end

        S_FETCH: begin
          // Request and address stay put until memory acknowledges.
          if (imem_ack) begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end
        end

        S_EXEC: begin
          // Priority: stall, then halt, then jump, then sequential.
          if (!stall) begin
            retire_cnt  <= cnt_inc;
            instr_valid <= 1'b0;
            if (halt_req) begin
              done  <= 1'b1;
              state <= S_HALTED;
            end else if (jump_en) begin
              if (jump_ok) begin
                pc       <= jump_target;
                imem_req <= 1'b1;
                state    <= S_FETCH;
              end else begin
                done  <= 1'b1;
                fault <= 1'b1;
                state <= S_HALTED;
              end
            end else if (seq_ok) begin
              pc       <= pc_inc[PC_W-1:0];
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              done  <= 1'b1;
              fault <= 1'b1;
              state <= S_HALTED;
            end
          end
        end

        S_HALTED: begin
          if (start) begin
            pc         <= START_VAL;
            retire_cnt <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
            imem_req   <= 1'b1;
            state      <= S_FETCH;
          end
        end

        default: begin
          state       <= S_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          done        <= 1'b0;
          fault       <= 1'b0;
        end
      endcase
    end
  end

endmodule
